mem_bus_arbiter: RTL

- Shares the single-port synchronous memory (1-cycle read latency, registered address) between two requesters: the stack-machine core (cpu) and an auxiliary master (aux, e.g. a GC or DMA engine).
- Decodes the hardware-register window. In-window accesses go to the io_* port instead of RAM.
- Returns read data to the owning requester with a valid strobe.
- Sits between the core/aux masters and the memory module.

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/mem_bus_arbiter_return_tracker.sv | 50 +++++
 rtl/mem_bus_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Bus-wide constants and requester IDs shared by the arbiter, return tracker and core.
package lisp_bus_pkg;

  localparam int          BUS_ADDR_W  = 16;
  localparam int          BUS_DATA_W  = 20;
  localparam int          VALUE_W     = 16;
  localparam int          TAG_W       = 4;
  localparam int          IO_OFF_W    = 7;
  localparam logic [15:0] BUS_IO_BASE = 16'hFF80;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_AUX = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_bus_arbiter_return_tracker.sv
// One-entry read-return tracker: remembers who issued the last granted read and
// whether it targeted RAM or the register window, then strobes that owner's rvalid.
module bus_return_tracker
  import lisp_bus_pkg::*;
#(
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  req_id_e           owner_i,
  input  logic              io_sel_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic [DATA_W-1:0] io_rdata_i,
  output logic              cpu_rvalid_o,
  output logic              aux_rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic    valid_q, valid_d;
  req_id_e owner_q, owner_d;
  logic    io_sel_q, io_sel_d;

  always_comb begin
    valid_d  = load_i;
    owner_d  = owner_q;
    io_sel_d = io_sel_q;
    if (load_i) begin
      owner_d  = owner_i;
      io_sel_d = io_sel_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      owner_q  <= REQ_CPU;
      io_sel_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      io_sel_q <= io_sel_d;
    end
  end

  assign cpu_rvalid_o = !rst_i && valid_q && (owner_q == REQ_CPU);
  assign aux_rvalid_o = !rst_i && valid_q && (owner_q == REQ_AUX);
  assign rdata_o      = io_sel_q ? io_rdata_i : mem_rdata_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of the single-port RAM with a hardware-register window.
// Handshake: a request is accepted in any cycle with req && gnt; masters hold req/addr/we/wdata until then.
module mem_bus_arbiter
  import lisp_bus_pkg::*;
#(
  parameter int                ADDR_W       = BUS_ADDR_W,
  parameter int                DATA_W       = BUS_DATA_W,
  parameter logic [ADDR_W-1:0] IO_BASE      = ADDR_W'(BUS_IO_BASE),
  parameter int                STARVE_LIMIT = 4,
  parameter int                LOCK_MAX     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic                cpu_we,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                aux_req,
  input  logic [ADDR_W-1:0]   aux_addr,
  input  logic                aux_we,
  input  logic [DATA_W-1:0]   aux_wdata,
  output logic                aux_gnt,
  output logic                aux_rvalid,
  output logic [DATA_W-1:0]   aux_rdata,
  input  logic                aux_lock,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [IO_OFF_W-1:0] io_addr,
  output logic                io_we,
  output logic                io_re,
  output logic [DATA_W-1:0]   io_wdata,
  input  logic [DATA_W-1:0]   io_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [3:0] LOCK_LIM   = 4'(LOCK_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       lock_own_q, lock_own_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       cpu_pref_q, cpu_pref_d;

  logic                lock_prio, starve_prio, aux_win, cpu_win, any_gnt;
  req_id_e             owner;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we, sel_io;
  logic [DATA_W-1:0]   sel_wdata, rdata;
  logic [IO_OFF_W-1:0] io_off;

  // cpu_pref_q lets the cpu win the first contested cycle after a lock is released.
  assign lock_prio   = lock_own_q && aux_req && aux_lock;
  assign starve_prio = (starve_cnt_q == STARVE_LIM) && !cpu_pref_q;
  assign aux_win     = !reset && aux_req && (lock_prio || starve_prio || !cpu_req);
  assign cpu_win     = !reset && cpu_req && !aux_win;
  assign any_gnt     = aux_win || cpu_win;

  assign cpu_gnt = cpu_win;
  assign aux_gnt = aux_win;

  assign owner     = aux_win ? REQ_AUX : REQ_CPU;
  assign sel_addr  = aux_win ? aux_addr  : cpu_addr;
  assign sel_we    = aux_win ? aux_we    : cpu_we;
  assign sel_wdata = aux_win ? aux_wdata : cpu_wdata;
  assign sel_io    = (sel_addr >= IO_BASE);
  assign io_off    = IO_OFF_W'(sel_addr - IO_BASE);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    io_addr   = '0;
    io_we     = 1'b0;
    io_re     = 1'b0;
    io_wdata  = '0;
    if (any_gnt) begin
      if (sel_io) begin
        io_addr  = io_off;
        io_we    = sel_we;
        io_re    = !sel_we;
        io_wdata = sel_wdata;
      end else begin
        mem_addr  = sel_addr;
        mem_we    = sel_we;
        mem_wdata = sel_wdata;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    lock_own_d   = lock_own_q;
    lock_cnt_d   = lock_cnt_q;
    cpu_pref_d   = cpu_pref_q;
    if (!aux_req || aux_win) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    if (cpu_req && aux_req) begin
      cpu_pref_d = 1'b0;
    end
    if (lock_own_q) begin
      if (lock_prio && aux_win) begin
        lock_cnt_d = lock_cnt_q + 4'd1;
        if (lock_cnt_d >= LOCK_LIM) begin
          lock_own_d = 1'b0;
          lock_cnt_d = '0;
          cpu_pref_d = 1'b1;
        end
      end else begin
        lock_own_d = 1'b0;
        lock_cnt_d = '0;
        cpu_pref_d = 1'b1;
      end
    end else if (aux_win && aux_lock) begin
      lock_own_d = (LOCK_LIM > 4'd1);
      lock_cnt_d = (LOCK_LIM > 4'd1) ? 4'd1 : 4'd0;
      cpu_pref_d = !(LOCK_LIM > 4'd1) || cpu_pref_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      lock_own_q   <= 1'b0;
      lock_cnt_q   <= '0;
      cpu_pref_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      lock_own_q   <= lock_own_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_pref_q   <= cpu_pref_d;
    end
  end

  bus_return_tracker #(
    .DATA_W(DATA_W)
  ) u_ret (
    .clk_i       (clk),
    .rst_i       (reset),
    .load_i      (any_gnt && !sel_we),
    .owner_i     (owner),
    .io_sel_i    (sel_io),
    .mem_rdata_i (mem_rdata),
    .io_rdata_i  (io_rdata),
    .cpu_rvalid_o(cpu_rvalid),
    .aux_rvalid_o(aux_rvalid),
    .rdata_o     (rdata)
  );

  assign cpu_rdata = rdata;
  assign aux_rdata = rdata;

endmodule
